// File: rtl/i2cs_pkg.sv
package i2cs_pkg;

  localparam logic [7:0] I2C_REG_ID        = 8'h00;
  localparam logic [7:0] I2C_REG_I2A_PUSH  = 8'h10;
  localparam logic [7:0] I2C_REG_I2A_FREE  = 8'h11;
  localparam logic [7:0] I2C_REG_A2I_HEAD  = 8'h20;
  localparam logic [7:0] I2C_REG_A2I_COUNT = 8'h21;

  localparam logic [7:0] I2C_ID_VALUE = 8'hA5;

  localparam logic [7:0] APB_OFF_DEV_ADDR   = 8'h00;
  localparam logic [7:0] APB_OFF_ENABLE     = 8'h04;
  localparam logic [7:0] APB_OFF_DEBOUNCE   = 8'h08;
  localparam logic [7:0] APB_OFF_SCL_DELAY  = 8'h0C;
  localparam logic [7:0] APB_OFF_SDA_DELAY  = 8'h10;
  localparam logic [7:0] APB_OFF_I2A_DATA   = 8'h14;
  localparam logic [7:0] APB_OFF_I2A_STATUS = 8'h18;
  localparam logic [7:0] APB_OFF_A2I_DATA   = 8'h1C;
  localparam logic [7:0] APB_OFF_A2I_STATUS = 8'h20;
  localparam logic [7:0] APB_OFF_FLUSH      = 8'h24;
  localparam logic [7:0] APB_OFF_IRQ_EN     = 8'h28;
  localparam logic [7:0] APB_OFF_CLR_FLAGS  = 8'h2C;

  localparam logic [6:0] DEV_ADDR_RST = 7'h62;
  localparam logic [7:0] DELAY_RST    = 8'h14;

  localparam int unsigned STAT_OVF_BIT  = 10;
  localparam int unsigned STAT_UNF_BIT  = 9;
  localparam int unsigned STAT_FULL_BIT = 8;

  function automatic logic [31:0] pack_status(input logic ovf, input logic unf,
                                              input logic full, input logic [7:0] count);
    logic [31:0] s;
    s                = '0;
    s[7:0]           = count;
    s[STAT_FULL_BIT] = full;
    s[STAT_UNF_BIT]  = unf;
    s[STAT_OVF_BIT]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/i2cs_sync_fifo.sv
module i2cs_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     clr_flags_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop frees the slot a same-cycle push needs, so a full FIFO accepts both.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = clr_flags_i ? 1'b0 : ovf_q;
    unf_d    = clr_flags_i ? 1'b0 : unf_q;
    if (push_i & ~do_push) ovf_d = 1'b1;
    if (pop_i & ~do_pop)   unf_d = 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/i2cs_reg_bank.sv
module i2cs_reg_bank
  import i2cs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned APB_AW     = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        i2c_reg_addr_i,
  input  logic [7:0]        i2c_reg_wdata_i,
  input  logic              i2c_reg_wrenable_i,
  input  logic              i2c_reg_rd_byte_complete_i,
  output logic [7:0]        i2c_reg_rddata_o,
  output logic [6:0]        i2c_dev_addr_o,
  output logic              i2c_enabled_o,
  output logic [7:0]        i2c_debounce_len_o,
  output logic [7:0]        i2c_scl_delay_len_o,
  output logic [7:0]        i2c_sda_delay_len_o,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              irq_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic apb_wr, apb_rd;
  logic sel_dev, sel_en, sel_deb, sel_scl, sel_sda, sel_i2a_data, sel_i2a_stat;
  logic sel_a2i_data, sel_a2i_stat, sel_flush, sel_irq_en, sel_clr;

  assign apb_wr = PSEL & PENABLE & PWRITE;
  assign apb_rd = PSEL & PENABLE & ~PWRITE;

  assign sel_dev      = (PADDR == APB_AW'(APB_OFF_DEV_ADDR));
  assign sel_en       = (PADDR == APB_AW'(APB_OFF_ENABLE));
  assign sel_deb      = (PADDR == APB_AW'(APB_OFF_DEBOUNCE));
  assign sel_scl      = (PADDR == APB_AW'(APB_OFF_SCL_DELAY));
  assign sel_sda      = (PADDR == APB_AW'(APB_OFF_SDA_DELAY));
  assign sel_i2a_data = (PADDR == APB_AW'(APB_OFF_I2A_DATA));
  assign sel_i2a_stat = (PADDR == APB_AW'(APB_OFF_I2A_STATUS));
  assign sel_a2i_data = (PADDR == APB_AW'(APB_OFF_A2I_DATA));
  assign sel_a2i_stat = (PADDR == APB_AW'(APB_OFF_A2I_STATUS));
  assign sel_flush    = (PADDR == APB_AW'(APB_OFF_FLUSH));
  assign sel_irq_en   = (PADDR == APB_AW'(APB_OFF_IRQ_EN));
  assign sel_clr      = (PADDR == APB_AW'(APB_OFF_CLR_FLAGS));

  logic [7:0]    i2a_rdata, a2i_rdata;
  logic [CW-1:0] i2a_count, a2i_count;
  logic          i2a_full, i2a_empty, i2a_ovf, i2a_unf;
  logic          a2i_full, a2i_empty, a2i_ovf, a2i_unf;

  i2cs_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_i2a_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (i2c_reg_wrenable_i & (i2c_reg_addr_i == I2C_REG_I2A_PUSH)),
    .pop_i       (apb_rd & sel_i2a_data),
    .flush_i     (apb_wr & sel_flush & PWDATA[0]),
    .clr_flags_i (apb_wr & sel_clr & PWDATA[0]),
    .wdata_i     (i2c_reg_wdata_i),
    .rdata_o     (i2a_rdata),
    .count_o     (i2a_count),
    .full_o      (i2a_full),
    .empty_o     (i2a_empty),
    .ovf_o       (i2a_ovf),
    .unf_o       (i2a_unf)
  );

  i2cs_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_a2i_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (apb_wr & sel_a2i_data),
    .pop_i       (i2c_reg_rd_byte_complete_i & (i2c_reg_addr_i == I2C_REG_A2I_HEAD)),
    .flush_i     (apb_wr & sel_flush & PWDATA[1]),
    .clr_flags_i (apb_wr & sel_clr & PWDATA[1]),
    .wdata_i     (PWDATA[7:0]),
    .rdata_o     (a2i_rdata),
    .count_o     (a2i_count),
    .full_o      (a2i_full),
    .empty_o     (a2i_empty),
    .ovf_o       (a2i_ovf),
    .unf_o       (a2i_unf)
  );

  logic [6:0] dev_addr_q, dev_addr_d;
  logic       enable_q, enable_d;
  logic [7:0] deb_q, deb_d;
  logic [7:0] scl_q, scl_d;
  logic [7:0] sda_q, sda_d;
  logic       irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  always_comb begin
    dev_addr_d = dev_addr_q;
    enable_d   = enable_q;
    deb_d      = deb_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    irq_en_d   = irq_en_q;
    if (apb_wr & sel_dev)    dev_addr_d = PWDATA[6:0];
    if (apb_wr & sel_en)     enable_d   = PWDATA[0];
    if (apb_wr & sel_deb)    deb_d      = PWDATA[7:0];
    if (apb_wr & sel_scl)    scl_d      = PWDATA[7:0];
    if (apb_wr & sel_sda)    sda_d      = PWDATA[7:0];
    if (apb_wr & sel_irq_en) irq_en_d   = PWDATA[0];
    irq_d = irq_en_q & (i2a_count != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dev_addr_q <= DEV_ADDR_RST;
      enable_q   <= 1'b0;
      deb_q      <= DELAY_RST;
      scl_q      <= DELAY_RST;
      sda_q      <= DELAY_RST;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      dev_addr_q <= dev_addr_d;
      enable_q   <= enable_d;
      deb_q      <= deb_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (sel_dev)      PRDATA = {25'b0, dev_addr_q};
    if (sel_en)       PRDATA = {31'b0, enable_q};
    if (sel_deb)      PRDATA = {24'b0, deb_q};
    if (sel_scl)      PRDATA = {24'b0, scl_q};
    if (sel_sda)      PRDATA = {24'b0, sda_q};
    if (sel_i2a_data) PRDATA = {24'b0, i2a_rdata};
    if (sel_i2a_stat) PRDATA = pack_status(i2a_ovf, i2a_unf, i2a_full, 8'(i2a_count));
    if (sel_a2i_stat) PRDATA = pack_status(a2i_ovf, a2i_unf, a2i_full, 8'(a2i_count));
    if (sel_irq_en)   PRDATA = {31'b0, irq_en_q};
  end

  logic [CW-1:0] i2a_free;
  assign i2a_free = CW'(FIFO_DEPTH) - i2a_count;

  always_comb begin
    i2c_reg_rddata_o = '0;
    unique case (i2c_reg_addr_i)
      I2C_REG_ID:        i2c_reg_rddata_o = I2C_ID_VALUE;
      I2C_REG_I2A_FREE:  i2c_reg_rddata_o = 8'(i2a_free);
      I2C_REG_A2I_HEAD:  i2c_reg_rddata_o = a2i_rdata;
      I2C_REG_A2I_COUNT: i2c_reg_rddata_o = 8'(a2i_count);
      default:           i2c_reg_rddata_o = '0;
    endcase
  end

  logic unused_sigs;
  assign unused_sigs = ^{PWDATA[31:8], i2a_empty, a2i_empty};

  assign i2c_dev_addr_o      = dev_addr_q;
  assign i2c_enabled_o       = enable_q;
  assign i2c_debounce_len_o  = deb_q;
  assign i2c_scl_delay_len_o = scl_q;
  assign i2c_sda_delay_len_o = sda_q;
  assign irq_o               = irq_q;
  assign PREADY              = 1'b1;
  assign PSLVERR             = 1'b0;

endmodule
